// File: rtl/gpu_array_pkg.sv
// Shared types and defaults for the systolic array and its edge feeder.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package gpu_array_pkg;

    // Operand and accumulator widths shared by systolic_array and systolic_feeder.
    localparam int DATA_W_DEF = 16;
    localparam int ACC_W_DEF  = 40;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feeder_state_e;

    // The last beat needs N-1 cycles to reach the far lane and another N-1
    // to cross the array diagonal, plus the cycle it lands in.
    function automatic int drain_cycles(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/skew_line.sv
// One lane of the diagonal skew: a DEPTH-stage shift line of {valid, data}.
// Latency: DEPTH cycles from in_* to out_* while shift_en is high.
// Backpressure: none; the line holds its contents whenever shift_en is low.
// Ports: clk/rst (sync, active-high), shift_en, in_valid/in_data, out_valid/out_data.
module skew_line #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [DEPTH-1:0]             vld_q;
    logic [DEPTH-1:0][DATA_W-1:0] dat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            dat_q <= '0;
        end else if (shift_en) begin
            vld_q[0] <= in_valid;
            dat_q[0] <= in_data;
            for (int s = 1; s < DEPTH; s++) begin
                vld_q[s] <= vld_q[s-1];
                dat_q[s] <= dat_q[s-1];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Skews K-step beats onto the west (A) and north (B) edges of systolic_array, then drains it.
// Latency: lane i shows a beat accepted at edge t during the cycle after edge t+i; tile_done 2N cycles after the last beat.
// Backpressure: in_ready is high in IDLE/FEED and low in DRAIN/DONE, independent of in_valid.
// Ports: clk/rst, in_a/in_b/in_valid/in_last/in_ready beat stream, a_west/a_valid/b_north/b_valid/array_en
//        to the array, tile_done pulse, beat_cnt, sticky err_overflow.
module systolic_feeder
    import gpu_array_pkg::*;
#(
    parameter int N      = 8,
    parameter int DATA_W = DATA_W_DEF,
    parameter int K_MAX  = 256
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [N-1:0][DATA_W-1:0] in_a,
    input  logic signed [N-1:0][DATA_W-1:0] in_b,
    input  logic                           in_valid,
    input  logic                           in_last,
    output logic                           in_ready,
    output logic signed [N-1:0][DATA_W-1:0] a_west,
    output logic [N-1:0]                   a_valid,
    output logic signed [N-1:0][DATA_W-1:0] b_north,
    output logic [N-1:0]                   b_valid,
    output logic                           array_en,
    output logic                           tile_done,
    output logic [$clog2(K_MAX+1)-1:0]     beat_cnt,
    output logic                           err_overflow
);

    localparam int DRAIN_CYC = drain_cycles(N);
    localparam int CNT_W     = $clog2(K_MAX + 1);
    localparam int DRN_W     = $clog2(DRAIN_CYC + 1);

    feeder_state_e    state_q;
    logic             array_en_q;
    logic             tile_done_q;
    logic [DRN_W-1:0] drn_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             accept;
    logic             shift_en;

    assign in_ready = (state_q == IDLE) || (state_q == FEED);
    assign accept   = in_valid && in_ready;
    // The first beat of a tile is taken in IDLE while array_en is still low,
    // so the lines must also shift on any accepted beat.
    assign shift_en = accept || array_en_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            array_en_q  <= 1'b0;
            tile_done_q <= 1'b0;
            drn_q       <= '0;
        end else begin
            tile_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        array_en_q <= 1'b1;
                        if (in_last) begin
                            state_q <= DRAIN;
                            drn_q   <= DRN_W'(DRAIN_CYC - 1);
                        end else begin
                            state_q <= FEED;
                        end
                    end
                end
                FEED: begin
                    if (accept && in_last) begin
                        state_q <= DRAIN;
                        drn_q   <= DRN_W'(DRAIN_CYC - 1);
                    end
                end
                DRAIN: begin
                    if (drn_q == '0) begin
                        state_q     <= DONE;
                        array_en_q  <= 1'b0;
                        tile_done_q <= 1'b1;
                    end else begin
                        drn_q <= drn_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    array_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Beat counter: restarts on a tile's first beat, saturates at K_MAX and
    // flags (stickily) any beat beyond that; the extra beat is still skewed out.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (accept) begin
            if (state_q == IDLE) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q == CNT_W'(K_MAX)) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Lane i of each edge is i+1 stages deep; bubbles and drain shift in {0,0}.
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_line #(.DEPTH(i + 1), .DATA_W(DATA_W)) u_a_line (
            .clk      (clk),
            .rst      (rst),
            .shift_en (shift_en),
            .in_valid (accept),
            .in_data  (accept ? in_a[i] : '0),
            .out_valid(a_valid[i]),
            .out_data (a_west[i])
        );
        skew_line #(.DEPTH(i + 1), .DATA_W(DATA_W)) u_b_line (
            .clk      (clk),
            .rst      (rst),
            .shift_en (shift_en),
            .in_valid (accept),
            .in_data  (accept ? in_b[i] : '0),
            .out_valid(b_valid[i]),
            .out_data (b_north[i])
        );
    end

    assign array_en     = array_en_q;
    assign tile_done    = tile_done_q;
    assign beat_cnt     = cnt_q;
    assign err_overflow = err_q;

endmodule
